// File: rtl/mux_n_reg.sv
// mux_n_reg: registered N-way multiplexer with a valid/ready handshake on both sides.
// One result is buffered in the output register. The input is ready whenever that
// buffer is empty or is being drained this cycle, so a stream moves at one word per clock.
// XferCount counts completed output transfers and wraps at 16 bits.
// Optional feature macro: MUXN_SEL_ERR_EN. When it is defined, SelError registers
// whether the accepted selection was out of range. When it is undefined, SelError is
// tied low. In both builds an out-of-range selection produces zero data.
module mux_n_reg #(
    parameter int MUXInputWidth = 32,
    parameter int MUXInputs     = 4,
    localparam int SelWidth     = (MUXInputs > 2) ? $clog2(MUXInputs) : 1
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic [MUXInputs*MUXInputWidth-1:0] MUXIn,
    input  logic [SelWidth-1:0]                MUXSelection,
    input  logic                               InValid,
    output logic                               InReady,
    output logic [MUXInputWidth-1:0]           MUXOut,
    output logic                               OutValid,
    input  logic                               OutReady,
    output logic                               SelError,
    output logic [15:0]                        XferCount
);

    logic [MUXInputWidth-1:0] channel [MUXInputs];
    logic [MUXInputWidth-1:0] selected;
    logic [MUXInputWidth-1:0] out_data;
    logic                     out_valid;
    logic [15:0]              xfer_count;
    logic                     accept;
    logic                     xfer;

    // Split the flattened input bus into one word per channel.
    for (genvar k = 0; k < MUXInputs; k++) begin : g_unpack
        assign channel[k] = MUXIn[k*MUXInputWidth +: MUXInputWidth];
    end

    // Handshake qualifiers. The buffer can take a new word when it is empty or
    // when its current word leaves in this same cycle.
    assign InReady = !out_valid || OutReady;
    assign accept  = InValid && InReady;
    assign xfer    = out_valid && OutReady;

    // Select the requested channel. A selection that matches no channel
    // (index >= MUXInputs) falls through to the zero default.
    always_comb begin
        selected = '0;
        for (int k = 0; k < MUXInputs; k++) begin
            if (MUXSelection == SelWidth'(k)) begin
                selected = channel[k];
            end
        end
    end

    // Output buffer: load on accept, drain on transfer. Reset wins over both.
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (accept) begin
            out_data  <= selected;
            out_valid <= 1'b1;
        end else if (xfer) begin
            out_valid <= 1'b0;
        end
    end

    // Count completed output transfers. The count wraps naturally at 16 bits.
    always_ff @(posedge CLK) begin
        if (RST) begin
            xfer_count <= 16'h0000;
        end else if (xfer) begin
            xfer_count <= xfer_count + 16'd1;
        end
    end

`ifdef MUXN_SEL_ERR_EN
    localparam logic [SelWidth:0] NUM_CH = MUXInputs[SelWidth:0];

    logic sel_error;

    // Range flag travels with the data word it describes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sel_error <= 1'b0;
        end else if (accept) begin
            sel_error <= ({1'b0, MUXSelection} >= NUM_CH);
        end
    end

    assign SelError = sel_error;
`else
    assign SelError = 1'b0;
`endif

    assign MUXOut    = out_data;
    assign OutValid  = out_valid;
    assign XferCount = xfer_count;

endmodule

// File: doc/mux_n_reg.md
MUX_N_REG -- requirements
Module: mux_n_reg

Interface
REQ-001 SHALL provide parameter MUXInputWidth, default 32, data width per input channel in bits.
REQ-002 SHALL provide parameter MUXInputs, default 4, number of input channels; legal range 2..16.
REQ-003 SHALL derive local parameter SelWidth as the ceiling of log2(MUXInputs), minimum 1.
REQ-004 SHALL provide port CLK  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL provide port RST  input  1  reset, synchronous and active-high.
REQ-006 SHALL provide port MUXIn  input  MUXInputs*MUXInputWidth  flattened inputs; channel k occupies bits [k*MUXInputWidth +: MUXInputWidth].
REQ-007 SHALL provide port MUXSelection  input  SelWidth  channel index, sampled on accept.
REQ-008 SHALL provide port InValid  input  1  upstream has a selection to transfer.
REQ-009 SHALL provide port InReady  output  1  block can accept this cycle.
REQ-010 SHALL provide port MUXOut  output  MUXInputWidth  registered selected data.
REQ-011 SHALL provide port OutValid  output  1  MUXOut holds an unconsumed result.
REQ-012 SHALL provide port OutReady  input  1  downstream consumes the result.
REQ-013 SHALL provide port SelError  output  1  registered flag: the current result came from an out-of-range selection.
REQ-014 SHALL provide port XferCount  output  16  count of completed output transfers.

Function
REQ-015 SHALL define accept as InValid && InReady, and transfer as OutValid && OutReady.
REQ-016 SHALL drive InReady combinationally as !OutValid || OutReady, giving full throughput: one accept per cycle while downstream is ready.
REQ-017 On accept, SHALL register the selected channel into MUXOut and set OutValid on the next edge, giving a latency of exactly 1 cycle.
REQ-018 On accept with MUXSelection >= MUXInputs, SHALL register MUXOut = 0.
REQ-019 SHALL clear OutValid on a transfer that coincides with no accept.
REQ-020 On simultaneous transfer and accept, SHALL keep OutValid at 1 and load the new data in the same edge.
REQ-021 While OutValid=1 and OutReady=0, SHALL hold MUXOut, SelError and OutValid stable and SHALL keep InReady at 0.
REQ-022 SHALL ignore MUXIn and MUXSelection in every cycle without an accept.
REQ-023 SHALL increment XferCount by 1 on each transfer and wrap from 16'hFFFF to 16'h0000.
REQ-024 SHALL hold XferCount unchanged in cycles without a transfer.

Reset
REQ-025 While RST=1 at a clock edge, SHALL set MUXOut=0, OutValid=0, SelError=0 and XferCount=0.
REQ-026 SHALL drive InReady=1 in the first cycle after reset, because OutValid=0.
REQ-027 An in-flight result at reset SHALL be discarded without being counted, and RST SHALL take priority over a simultaneous accept or transfer.

Configuration
REQ-028 SHALL use macro MUXN_SEL_ERR_EN to compile out-of-range detection in or out.
REQ-029 With MUXN_SEL_ERR_EN defined, SHALL register SelError = (MUXSelection >= MUXInputs) on each accept and hold it with MUXOut.
REQ-030 Without MUXN_SEL_ERR_EN, SHALL tie SelError to constant 0; MUXOut SHALL still be 0 for an out-of-range selection.
REQ-031 SHALL keep the port list identical in both configurations.

Verification
REQ-032 SHALL cover basic select: defaults, MUXIn channels = 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, OutReady=1, InValid=1 with MUXSelection=2 -> the next cycle shows MUXOut=32'h33333333, OutValid=1, XferCount incrementing to 1.
REQ-033 SHALL cover backpressure: OutReady=0 for 3 cycles after one accept -> InReady=0 and MUXOut/OutValid stable; OutReady=1 -> one transfer, XferCount+1, and no lost or duplicated data.
REQ-034 SHALL cover streaming: InValid=1, OutReady=1 for 10 cycles with selection cycling 0..3 -> 10 transfers in 11 cycles, XferCount=10, with data matching selection order.
REQ-035 SHALL cover out-of-range: MUXInputs=3, MUXSelection=3 accepted -> MUXOut=0, and SelError=1 with MUXN_SEL_ERR_EN defined and 0 without it.
REQ-036 SHALL cover mid-operation reset: RST=1 while OutValid=1 and OutReady=0 -> next cycle OutValid=0, XferCount=0, InReady=1.
REQ-037 SHALL cover wrap-around: XferCount preloaded by 65535 transfers, then one more transfer -> XferCount=0.
